memory_reader: RTL and testbench

Consumer side of the instruction memory. It fetches 32-bit words sequentially from the instruction RAM port, up to the writer's cursor, and delivers them to the decode stage over a valid/ready handshake. A 2-entry output buffer sustains one word per cycle. A redirect input re-points the fetch address and flushes all buffered and in-flight data.

---
 rtl/memory_reader.sv | 155 +++++++++++++++
 tb/tb_memory_reader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_reader.sv
// rtl/memory_reader.sv - sequential instruction fetch from RAM into a 2-entry output buffer
//
// Purpose:
//    Reads 32-bit words from the instruction RAM, one address at a time, from
//    fetch_ptr up to (not including) the writer's cursor. Returned words go into
//    a 2-deep {addr, data} buffer that feeds decode over valid/ready. This
//    sustains one word per cycle. A redirect restarts fetch at a new address and
//    drops everything buffered or in flight.
//
// Ports:
//    clk, rst_n       rising-edge clock, asynchronous active-low reset
//    wr_cursor        writer's next free address; [fetch_ptr, wr_cursor) is readable
//    redirect         one-cycle pulse: restart fetch at redirect_addr
//    redirect_addr    new fetch address
//    ram_rd_en        RAM read strobe
//    ram_addr         RAM read address (the fetch pointer)
//    ram_rdata        RAM read data, valid the cycle after ram_rd_en
//    instr_valid      buffer head holds a word
//    instr_ready      consumer accepts the head word
//    instr_data       head word data
//    instr_addr       head word RAM address
//    rd_cursor        address of the oldest word not yet consumed

module memory_reader #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] wr_cursor,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [DATA_W-1:0] instr_data,
   output logic [ADDR_W-1:0] instr_addr,
   output logic [ADDR_W-1:0] rd_cursor
);

   logic [ADDR_W-1:0] fetch_ptr_q, fetch_ptr_d;
   logic              inflight_q, inflight_d;
   logic              kill_q, kill_d;
   logic [ADDR_W-1:0] infl_addr_q, infl_addr_d;
   logic [1:0]        count_q, count_d;
   // Entry 0 is always the head; entry 1 shifts down on pop.
   logic [ADDR_W-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
   logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;

   logic       avail;
   logic       pop;
   logic       push;
   logic [2:0] occ;

   assign avail       = (fetch_ptr_q != wr_cursor);
   assign instr_valid = (count_q != 2'd0);
   assign instr_data  = data0_q;
   assign instr_addr  = addr0_q;
   assign ram_addr    = fetch_ptr_q;
   assign pop         = instr_valid && instr_ready;
   assign push        = inflight_q && !kill_q;
   assign occ         = {1'b0, count_q} + {2'b00, inflight_q};

   // A word leaving this cycle frees its slot for a read issued this cycle,
   // so issue resumes on the same cycle ready returns. The strobe is gated by
   // rst_n so it drops immediately while reset is held.
   assign ram_rd_en = rst_n && avail && !redirect && (occ < (3'd2 + {2'b00, pop}));

   // Oldest unconsumed word: buffer head, else the live in-flight read, else
   // the next address to fetch.
   assign rd_cursor = (count_q != 2'd0)      ? addr0_q     :
                      (inflight_q && !kill_q) ? infl_addr_q : fetch_ptr_q;

   always_comb begin
      fetch_ptr_d = fetch_ptr_q;
      infl_addr_d = infl_addr_q;
      inflight_d  = ram_rd_en;
      // The return landing during the redirect cycle is dropped by the flush;
      // kill covers any return that would land in the cycle after it.
      kill_d      = redirect;
      count_d     = count_q;
      addr0_d     = addr0_q;
      data0_d     = data0_q;
      addr1_d     = addr1_q;
      data1_d     = data1_q;

      if (ram_rd_en) begin
         fetch_ptr_d = fetch_ptr_q + ADDR_W'(1);
         infl_addr_d = fetch_ptr_q;
      end

      if (redirect) begin
         fetch_ptr_d = redirect_addr;
         count_d     = 2'd0;
      end else begin
         case ({push, pop})
            2'b11: begin
               if (count_q == 2'd1) begin
                  addr0_d = infl_addr_q;
                  data0_d = ram_rdata;
               end else begin
                  addr0_d = addr1_q;
                  data0_d = data1_q;
                  addr1_d = infl_addr_q;
                  data1_d = ram_rdata;
               end
            end
            2'b01: begin
               addr0_d = addr1_q;
               data0_d = data1_q;
               count_d = count_q - 2'd1;
            end
            2'b10: begin
               if (count_q == 2'd0) begin
                  addr0_d = infl_addr_q;
                  data0_d = ram_rdata;
               end else begin
                  addr1_d = infl_addr_q;
                  data1_d = ram_rdata;
               end
               count_d = count_q + 2'd1;
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_ptr_q <= '0;
         inflight_q  <= 1'b0;
         kill_q      <= 1'b0;
         infl_addr_q <= '0;
         count_q     <= 2'd0;
         addr0_q     <= '0;
         data0_q     <= '0;
         addr1_q     <= '0;
         data1_q     <= '0;
      end else begin
         fetch_ptr_q <= fetch_ptr_d;
         inflight_q  <= inflight_d;
         kill_q      <= kill_d;
         infl_addr_q <= infl_addr_d;
         count_q     <= count_d;
         addr0_q     <= addr0_d;
         data0_q     <= data0_d;
         addr1_q     <= addr1_d;
         data1_q     <= data1_d;
      end
   end

endmodule

// File: tb/tb_memory_reader.sv
// tb/tb_memory_reader.sv - self-checking bench for memory_reader

module tb_memory_reader;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [ADDR_W-1:0] wr_cursor;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_addr;
   logic              ram_rd_en;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_rdata;
   logic              instr_valid;
   logic              instr_ready;
   logic [DATA_W-1:0] instr_data;
   logic [ADDR_W-1:0] instr_addr;
   logic [ADDR_W-1:0] rd_cursor;

   logic [DATA_W-1:0] ram [1024];

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: the consumer must see a gap-free ascending address
   // sequence starting at exp_ptr, restarted by reset and by redirect.
   logic [ADDR_W-1:0] exp_ptr;
   logic              hold_q;
   logic [ADDR_W-1:0] hold_addr;
   logic [DATA_W-1:0] hold_data;

   int cyc;
   int n_rd, first_rd, last_rd;
   int n_val, first_val, last_val;
   int n_pop;
   logic [ADDR_W-1:0] first_val_addr;
   int red_cyc;

   memory_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .wr_cursor     (wr_cursor),
      .redirect      (redirect),
      .redirect_addr (redirect_addr),
      .ram_rd_en     (ram_rd_en),
      .ram_addr      (ram_addr),
      .ram_rdata     (ram_rdata),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr_data    (instr_data),
      .instr_addr    (instr_addr),
      .rd_cursor     (rd_cursor)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_rd_en) ram_rdata <= ram[ram_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   task automatic clear_stats();
      n_rd = 0; first_rd = -1; last_rd = -1;
      n_val = 0; first_val = -1; last_val = -1;
      n_pop = 0; first_val_addr = '0;
   endtask

   // One clock: sample at the falling edge, update the model, return at posedge+1.
   task automatic step();
      logic [ADDR_W-1:0] ahead;
      @(negedge clk);
      if (hold_q) begin
         check("hold_valid", instr_valid, 1'b1);
         check("hold_addr", instr_addr, hold_addr);
         check("hold_data", instr_data, hold_data);
      end
      check("rd_cursor", rd_cursor, exp_ptr);
      ahead = ram_addr - exp_ptr;
      check("ahead_le2", ahead <= 10'd2, 1'b1);
      if (ram_rd_en) check("rd_in_window", ram_addr != wr_cursor, 1'b1);
      if (redirect) check("no_rd_on_redirect", ram_rd_en, 1'b0);
      if (ram_rd_en) begin
         n_rd++;
         if (first_rd < 0) first_rd = cyc;
         last_rd = cyc;
      end
      if (instr_valid) begin
         n_val++;
         if (first_val < 0) begin
            first_val = cyc;
            first_val_addr = instr_addr;
         end
         last_val = cyc;
      end
      if (instr_valid && instr_ready) begin
         check("pop_addr", instr_addr, exp_ptr);
         check("pop_data", instr_data, ram[exp_ptr]);
         exp_ptr = exp_ptr + 10'd1;
         n_pop++;
      end
      if (redirect) exp_ptr = redirect_addr;
      hold_q    = instr_valid && !instr_ready && !redirect;
      hold_addr = instr_addr;
      hold_data = instr_data;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset(input logic [ADDR_W-1:0] wc);
      wr_cursor = wc;
      redirect  = 1'b0;
      rst_n     = 1'b0;
      #1;
      check("rst_rd_en", ram_rd_en, 1'b0);
      check("rst_valid", instr_valid, 1'b0);
      check("rst_data", instr_data, 32'd0);
      check("rst_addr", instr_addr, 10'd0);
      check("rst_rd_cursor", rd_cursor, 10'd0);
      check("rst_ram_addr", ram_addr, 10'd0);
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      exp_ptr = '0;
      hold_q  = 1'b0;
      cyc     = 0;
      clear_stats();
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = $urandom;
      for (int i = 0; i < 6; i++) ram[i] = 32'hA0 + i;
      rst_n = 1'b1; wr_cursor = '0; redirect = 1'b0; redirect_addr = '0;
      instr_ready = 1'b1; cyc = 0; exp_ptr = '0; hold_q = 1'b0;
      clear_stats();
      #2;

      // Streaming fetch of six words.
      instr_ready = 1'b1;
      do_reset(10'd6);
      repeat (12) step();
      check("stream_n_rd", n_rd, 6);
      check("stream_first_rd", first_rd, 0);
      check("stream_last_rd", last_rd, 5);
      check("stream_first_val", first_val, 2);
      check("stream_last_val", last_val, 7);
      check("stream_n_pop", n_pop, 6);
      check("stream_end_cursor", rd_cursor, 10'd6);
      check("stream_end_valid", instr_valid, 1'b0);

      // Backpressure: only two reads outstanding, issue resumes with ready.
      instr_ready = 1'b0;
      do_reset(10'd6);
      repeat (5) step();
      check("bp_n_rd", n_rd, 2);
      check("bp_head_data", instr_data, 32'hA0);
      instr_ready = 1'b1;
      #1;
      check("bp_resume_rd", ram_rd_en, 1'b1);
      repeat (10) step();
      check("bp_n_pop", n_pop, 6);
      check("bp_n_rd_total", n_rd, 6);

      // Wrap-around from 1022 through 0.
      do_reset(10'd0);
      redirect = 1'b1; redirect_addr = 10'd1022; wr_cursor = 10'd2;
      red_cyc = cyc;
      step();
      redirect = 1'b0;
      clear_stats();
      repeat (8) step();
      check("wrap_first_rd", first_rd, red_cyc + 1);
      check("wrap_first_val", first_val, red_cyc + 3);
      check("wrap_first_addr", first_val_addr, 10'd1022);
      check("wrap_n_pop", n_pop, 4);
      check("wrap_end_cursor", rd_cursor, 10'd2);

      // Redirect mid-stream with a simultaneous pop and a read in flight.
      do_reset(10'd110);
      repeat (3) step();
      redirect = 1'b1; redirect_addr = 10'd100;
      #1;
      check("redir_pop_valid", instr_valid, 1'b1);
      red_cyc = cyc;
      n_pop = 0;
      step();
      check("redir_pop_counted", n_pop, 1);
      redirect = 1'b0;
      clear_stats();
      repeat (8) step();
      check("redir_first_rd", first_rd, red_cyc + 1);
      check("redir_first_val", first_val, red_cyc + 3);
      check("redir_first_addr", first_val_addr, 10'd100);

      // Asynchronous reset with two words buffered.
      instr_ready = 1'b0;
      do_reset(10'd6);
      repeat (4) step();
      check("areset_pre_valid", instr_valid, 1'b1);
      #3;
      do_reset(10'd6);
      instr_ready = 1'b1;
      repeat (10) step();
      check("areset_first_addr", first_val_addr, 10'd0);
      check("areset_n_pop", n_pop, 6);

      // Randomized run: moving writer, random ready, occasional redirects.
      instr_ready = 1'b1;
      do_reset(10'd0);
      for (int i = 0; i < 3000; i++) begin
         logic [ADDR_W-1:0] gap;
         instr_ready = ($urandom_range(0, 3) != 0);
         gap = wr_cursor - exp_ptr;
         if ($urandom_range(0, 2) == 0 && gap < 10'd900) wr_cursor = wr_cursor + 10'd1;
         if (!redirect && $urandom_range(0, 59) == 0) begin
            redirect = 1'b1;
            redirect_addr = wr_cursor - 10'($urandom_range(0, 30));
         end else begin
            redirect = 1'b0;
         end
         step();
      end
      redirect = 1'b0;
      instr_ready = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (rd_cursor == wr_cursor && !instr_valid && !ram_rd_en) break;
         step();
      end
      check("drain_done", (rd_cursor == wr_cursor) && !instr_valid && !ram_rd_en, 1'b1);
      check("drain_model", exp_ptr, wr_cursor);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
